// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port req/gnt arbiter in front of a single-port data memory.
// DMEM_ARB_FIXED_PRIO_EN selects fixed port-0 priority instead of round-robin.
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    typedef enum logic {IDLE, RDRESP} state_t;
    state_t state_q, state_d;
    logic owner_q, owner_d;
    logic win0, win1, idle_ok, rd_grant, resp;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign win0 = p0_req;
`else
    logic ptr_q, ptr_d;
    assign win0 = p0_req & (~p1_req | ~ptr_q);
    assign ptr_d = p0_gnt ? 1'b1 : p1_gnt ? 1'b0 : ptr_q;
    always_ff @(posedge clk) ptr_q <= rst ? 1'b0 : ptr_d;
`endif
    assign win1 = p1_req & ~win0;
    assign idle_ok = (state_q == IDLE) & ~rst;
    assign p0_gnt = idle_ok & win0;
    assign p1_gnt = idle_ok & win1;
    assign mem_en = p0_gnt | p1_gnt;
    assign mem_we = p0_gnt ? p0_we : p1_gnt ? p1_we : 1'b0;
    assign mem_addr = p0_gnt ? p0_addr : p1_gnt ? p1_addr : '0;
    assign mem_wdata = p0_gnt ? p0_wdata : p1_gnt ? p1_wdata : '0;
    assign rd_grant = mem_en & ~mem_we;
    always_comb begin
        state_d = IDLE;
        owner_d = owner_q;
        if (state_q == IDLE && rd_grant) begin
            state_d = RDRESP;
            owner_d = p1_gnt;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end
    // Gating with rst drops a read that was in flight when reset hit.
    assign resp = (state_q == RDRESP) & ~rst;
    assign p0_rvalid = resp & ~owner_q;
    assign p1_rvalid = resp & owner_q;
    assign p0_rdata = p0_rvalid ? mem_rdata : '0;
    assign p1_rdata = p1_rvalid ? mem_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven cycle vectors plus hand sequences for read throughput and handshake.
module tb_dmem_arbiter;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
    logic p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, mem_en, mem_we;
    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 0;
    logic [31:0] mem [0:31];
    logic loaded = 1'b0;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 32; i++) mem[i] <= (i == 2) ? 32'd2 : (i == 5) ? 32'h5A5A : 32'd0;
            loaded <= 1'b1;
        end else if (mem_en && mem_we) begin
            mem[mem_addr[6:2]] <= mem_wdata;
        end else if (mem_en) begin
            mem_rdata <= mem[mem_addr[6:2]];
        end
    end

    typedef struct {
        logic rst, r0, w0;
        logic [31:0] a0, d0;
        logic r1, w1;
        logic [31:0] a1, d1;
        logic g0, g1, v0, v1, en, we;
        logic [31:0] rd0, rd1, addr, wd;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic rs, r0, w0, input logic [31:0] a0, d0,
                       input logic r1, w1, input logic [31:0] a1, d1,
                       input logic g0, g1, v0, v1, en, we,
                       input logic [31:0] rd0, rd1, addr, wd);
        vec_t v;
        v.rst = rs; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.en = en; v.we = we;
        v.rd0 = rd0; v.rd1 = rd1; v.addr = addr; v.wd = wd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        //  rst r0 w0 a0      d0        r1 w1 a1      d1       g0 g1 v0 v1 en we rd0  rd1      addr     wd
        add(1, 1, 0, 32'h08, 0,        1, 0, 32'h14, 0,       0, 0, 0, 0, 0, 0, 0,   0,       0,       0);
        add(1, 1, 0, 32'h08, 0,        1, 0, 32'h14, 0,       0, 0, 0, 0, 0, 0, 0,   0,       0,       0);
        add(0, 1, 0, 32'h08, 0,        1, 0, 32'h14, 0,       1, 0, 0, 0, 1, 0, 0,   0,       32'h08,  0);
        add(0, 0, 0, 0,      0,        1, 0, 32'h14, 0,       0, 0, 1, 0, 0, 0, 2,   0,       0,       0);
        add(0, 0, 0, 0,      0,        1, 0, 32'h14, 0,       0, 1, 0, 0, 1, 0, 0,   0,       32'h14,  0);
        add(0, 1, 1, 32'h10, 32'h1234, 0, 0, 0,      0,       0, 0, 0, 1, 0, 0, 0,   32'h5A5A, 0,      0);
        add(0, 1, 1, 32'h10, 32'h1234, 0, 0, 0,      0,       1, 0, 0, 0, 1, 1, 0,   0,       32'h10,  32'h1234);
        add(0, 0, 0, 0,      0,        1, 0, 32'h10, 0,       0, 1, 0, 0, 1, 0, 0,   0,       32'h10,  0);
        add(0, 0, 0, 0,      0,        0, 0, 0,      0,       0, 0, 0, 1, 0, 0, 0,   32'h1234, 0,      0);
        add(0, 1, 1, 32'h20, 32'h11,   1, 1, 32'h24, 32'h22,  1, 0, 0, 0, 1, 1, 0,   0,       32'h20,  32'h11);
        add(0, 1, 1, 32'h28, 32'h33,   1, 1, 32'h24, 32'h22,  FIXED, !FIXED, 0, 0, 1, 1, 0, 0,
            FIXED ? 32'h28 : 32'h24, FIXED ? 32'h33 : 32'h22);
        add(0, 1, 1, 32'h28, 32'h33,   1, 1, 32'h24, 32'h22,  1, 0, 0, 0, 1, 1, 0,   0,       32'h28,  32'h33);
        add(0, 1, 1, 32'h30, 32'h55,   1, 1, 32'h24, 32'h22,  FIXED, !FIXED, 0, 0, 1, 1, 0, 0,
            FIXED ? 32'h30 : 32'h24, FIXED ? 32'h55 : 32'h22);
        add(0, 1, 0, 32'h08, 0,        0, 0, 0,      0,       1, 0, 0, 0, 1, 0, 0,   0,       32'h08,  0);
        add(1, 0, 0, 0,      0,        0, 0, 0,      0,       0, 0, 0, 0, 0, 0, 0,   0,       0,       0);
        add(0, 1, 1, 32'h38, 32'h77,   1, 1, 32'h3C, 32'h88,  1, 0, 0, 0, 1, 1, 0,   0,       32'h38,  32'h77);
        add(0, 0, 0, 0,      0,        1, 1, 32'h3C, 32'h88,  0, 1, 0, 0, 1, 1, 0,   0,       32'h3C,  32'h88);
        add(0, 0, 0, 0,      0,        1, 0, 32'h10, 0,       0, 1, 0, 0, 1, 0, 0,   0,       32'h10,  0);
        add(1, 0, 0, 0,      0,        0, 0, 0,      0,       0, 0, 0, 0, 0, 0, 0,   0,       0,       0);
        add(0, 0, 0, 0,      0,        0, 0, 0,      0,       0, 0, 0, 0, 0, 0, 0,   0,       0,       0);
        add(0, 1, 1, 32'h40, 32'h1,    1, 1, 32'h44, 32'h2,   1, 0, 0, 0, 1, 1, 0,   0,       32'h40,  32'h1);
        add(0, 0, 0, 0,      0,        0, 0, 0,      0,       0, 0, 0, 0, 0, 0, 0,   0,       0,       0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst = vecs[i].rst;
            p0_req = vecs[i].r0; p0_we = vecs[i].w0; p0_addr = vecs[i].a0; p0_wdata = vecs[i].d0;
            p1_req = vecs[i].r1; p1_we = vecs[i].w1; p1_addr = vecs[i].a1; p1_wdata = vecs[i].d1;
            #4;
            chk($sformatf("s%0d ctrl", i), {58'd0, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_en, mem_we},
                {58'd0, vecs[i].g0, vecs[i].g1, vecs[i].v0, vecs[i].v1, vecs[i].en, vecs[i].we});
            chk($sformatf("s%0d rdata", i), {p0_rdata, p1_rdata}, {vecs[i].rd0, vecs[i].rd1});
            chk($sformatf("s%0d bus", i), {mem_addr, mem_wdata}, {vecs[i].addr, vecs[i].wd});
        end

        begin
            int g, v;
            logic [31:0] last;
            g = 0; v = 0; last = 0;
            for (int c = 0; c < 4; c++) begin
                @(posedge clk);
                #1;
                p0_req = 1; p0_we = 0; p0_addr = 32'h08; p0_wdata = 0;
                p1_req = 0;
                #4;
                g += p0_gnt;
                v += p0_rvalid;
                if (p0_rvalid) last = p0_rdata;
            end
            chk("rd_thru gnts", 64'(g), 64'd2);
            chk("rd_thru rvalids", 64'(v), 64'd2);
            chk("rd_thru rdata", {32'd0, last}, {32'd0, 32'd2});
        end

        begin
            bit seen;
            @(posedge clk);
            #1;
            p0_req = 0;
            p1_req = 1; p1_we = 0; p1_addr = 32'h10; p1_wdata = 0;
            seen = 0;
            for (int c = 0; c < 5 && !seen; c++) begin
                #4;
                if (p1_gnt) seen = 1;
                @(posedge clk);
                #1;
            end
            p1_req = 0;
            chk("hs gnt seen", {63'd0, seen}, 64'd1);
            seen = 0;
            for (int c = 0; c < 5 && !seen; c++) begin
                #4;
                if (p1_rvalid) begin
                    seen = 1;
                    chk("hs rdata", {32'd0, p1_rdata}, {32'd0, 32'h1234});
                end
                @(posedge clk);
                #1;
            end
            chk("hs rvalid seen", {63'd0, seen}, 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
